// File: rtl/fetch_branch_resolver_if.sv
// ---------------------------------------------------------------------------
// fetch_branch_resolver_if
//   Signal bundle between the fetch/branch resolver, the PC counter, the
//   instruction ROM and the downstream decode stage.
//
//   Signals:
//     pc              PC from the counter (word index)
//     alu_zero        ALU compare zero flag for the instruction in decode
//     imem_addr       ROM read address (equals pc)
//     imem_rdata      ROM read data, one cycle after imem_addr
//     instr           decode-stage instruction
//     instr_valid     instr is architecturally valid
//     branch          counter takes incrementOffset on this edge
//     incrementOffset signed word offset for the counter
//     retired_cnt     count of valid instructions
//
//   Modports:
//     slave  : the resolver's view (consumes pc/alu_zero/rdata)
//     master : the environment's view (counter, ROM, ALU, decode)
//
//   Handshake: there is no back-pressure. A word on imem_rdata in cycle t+1
//   belongs to the pc presented in cycle t; instr_valid qualifies instr in
//   the same cycle, and branch is only ever asserted together with
//   instr_valid.
// ---------------------------------------------------------------------------
interface fetch_branch_resolver_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic [PC_W-1:0]    pc;
    logic               alu_zero;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               branch;
    logic [PC_W-1:0]    incrementOffset;
    logic [CNT_W-1:0]   retired_cnt;

    modport slave (
        input  pc,
        input  alu_zero,
        input  imem_rdata,
        output imem_addr,
        output instr,
        output instr_valid,
        output branch,
        output incrementOffset,
        output retired_cnt
    );

    modport master (
        output pc,
        output alu_zero,
        output imem_rdata,
        input  imem_addr,
        input  instr,
        input  instr_valid,
        input  branch,
        input  incrementOffset,
        input  retired_cnt
    );
endinterface

// File: rtl/fetch_branch_resolver.sv
// ---------------------------------------------------------------------------
// fetch_branch_resolver
//   Presents the counter PC to a 1-cycle-latency instruction ROM, marks the
//   returned word valid, resolves JAL/BEQ/BNE and steers the PC counter.
//   After a taken branch the next (sequential, wrong-path) word is squashed.
//   Valid instructions are counted in a wrapping retired counter.
//
//   Ports:
//     clk          system clock, rising edge
//     rst          asynchronous active-high reset
//     bus          fetch_branch_resolver_if.slave (see interface header)
//     dbg_state_o  current FSM state (0=FILL, 1=RUN, 2=SQUASH)
// ---------------------------------------------------------------------------
module fetch_branch_resolver #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_branch_resolver_if.slave bus,
    output logic [1:0]             dbg_state_o
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2
    } state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [INSTR_W-1:0] instr_w;
    logic [6:0]         opcode_w;
    logic [2:0]         funct3_w;
    logic               is_jal_w, is_beq_w, is_bne_w, taken_w;
    logic [PC_W-1:0]    jal_words_w, br_words_w, off_calc_w;

    logic               valid_w;
    logic               branch_w;
    logic [PC_W-1:0]    off_w;

    assign instr_w  = bus.imem_rdata;
    assign opcode_w = instr_w[6:0];
    assign funct3_w = instr_w[14:12];

    assign is_jal_w = (opcode_w == OP_JAL);
    assign is_beq_w = (opcode_w == OP_BRANCH) && (funct3_w == F3_BEQ);
    assign is_bne_w = (opcode_w == OP_BRANCH) && (funct3_w == F3_BNE);
    assign taken_w  = is_jal_w
                    | (is_beq_w &  bus.alu_zero)
                    | (is_bne_w & ~bus.alu_zero);

    // Immediates already shifted right by 2 (byte -> word offset): the
    // reassembly starts at imm[2], so imm[1] (no compressed support) and
    // imm[0] never enter the arithmetic. Sign bit is replicated to 32 bits
    // and then truncated to the PC width (modular wrap).
    assign jal_words_w = PC_W'({{13{instr_w[31]}}, instr_w[31], instr_w[19:12],
                                instr_w[20], instr_w[30:22]});
    assign br_words_w  = PC_W'({{21{instr_w[31]}}, instr_w[31], instr_w[7],
                                instr_w[30:25], instr_w[11:9]});

    // -1 because the counter has already stepped past the branch word by the
    // time the branch is resolved.
    assign off_calc_w = (is_jal_w ? jal_words_w : br_words_w) - PC_W'(1);

    always_comb begin
        state_d  = state_q;
        valid_w  = 1'b0;
        branch_w = 1'b0;
        off_w    = '0;
        unique case (state_q)
            FILL: begin
                state_d = RUN;
            end
            RUN: begin
                valid_w = 1'b1;
                if (taken_w) begin
                    branch_w = 1'b1;
                    off_w    = off_calc_w;
                    state_d  = SQUASH;
                end
            end
            SQUASH: begin
                // Wrong-path word: decode ignored regardless of content.
                state_d = RUN;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign cnt_d = valid_w ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_addr       = bus.pc;
    assign bus.instr           = instr_w;
    assign bus.instr_valid     = valid_w;
    assign bus.branch          = branch_w;
    assign bus.incrementOffset = off_w;
    assign bus.retired_cnt     = cnt_q;
    assign dbg_state_o         = state_q;

endmodule

// File: doc/fetch_branch_resolver.md
Name: fetch_branch_resolver

Overview:
- Instruction-side partner of the 8-bit word-indexed PC counter. Each cycle it presents the counter's PC to a synchronous instruction ROM with 1-cycle read latency, and captures the returned word.
- It decodes JAL/BEQ/BNE and drives the counter's `branch` and `incrementOffset` inputs.
- After a taken branch it squashes the wrong-path slot. It also keeps a count of retired instructions.

Parameters:
- PC_W, 8, PC and offset width in instruction words; must match the PC counter.
- INSTR_W, 32, instruction width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc  in  PC_W  current PC from the counter.
- alu_zero  in  1  zero flag from the ALU compare for the instruction in decode.
- imem_addr  out  PC_W  ROM read address.
- imem_rdata  in  INSTR_W  ROM data; valid the cycle after the address is presented.
- instr  out  INSTR_W  decoded-stage instruction.
- instr_valid  out  1  instr is architecturally valid (not bubble or squash).
- branch  out  1  to PC counter: take incrementOffset this edge.
- incrementOffset  out  PC_W  to PC counter: signed word offset.
- retired_cnt  out  CNT_W  count of valid instructions.

Behaviour:
- `imem_addr = pc` (combinational). `instr = imem_rdata`. Word at cycle t+1 belongs to the PC of cycle t.
- FSM states, with per-state outputs:
  - FILL:
    - Entered on async reset assertion and held while rst=1.
    - On the first clk edge with rst=0, goes to RUN.
    - Outputs `instr_valid=0`, `branch=0`.
  - RUN:
    - `instr_valid=1`.
    - If the decoded instruction is taken, `branch=1` and next state is SQUASH; otherwise `branch=0` and the FSM stays in RUN.
  - SQUASH:
    - Exactly one cycle. `instr_valid=0`, `branch=0`; decode is ignored, even if the word is itself a branch.
    - Next state is RUN.
- Taken conditions (RUN only):
  - JAL (opcode 1101111): always taken.
  - BEQ (opcode 1100011, funct3 000): taken if `alu_zero=1`.
  - BNE (opcode 1100011, funct3 001): taken if `alu_zero=0`.
  - Other funct3 values, other opcodes, and JALR: never taken.
- Offset arithmetic:
  - imm is the standard sign-extended byte offset: J-type 21-bit, B-type 13-bit.
  - `incrementOffset = ((imm >>> 2) - 1)` truncated to PC_W bits, two's complement. The -1 compensates for the counter having already advanced past the branch.
  - Modular wrap at 2^PC_W. imm[1] is ignored (no compressed support).
  - When `branch=0`, incrementOffset is driven 0.
- Squash rationale: on the edge where `branch=1`, the counter jumps to the target. The ROM word returned on the following cycle is the sequential (wrong-path) word and must never be marked valid.
- retired_cnt:
  - Increments on each clk edge where `instr_valid=1`.
  - Wraps at 2^CNT_W to 0.
- Reset values: state=FILL, `instr_valid=0`, `branch=0`, `incrementOffset=0`, `retired_cnt=0`.
- Reset mid-operation (any state, including SQUASH): all of the above are forced immediately and asynchronously.
- `branch` is a registered-state-gated combinational output. It must never be 1 in FILL or SQUASH, or during rst.

Test Plan:
- Reset/fill:
  - Stimulus: assert rst mid-RUN, then release; ROM holds NOPs (0x00000013).
  - Required: `instr_valid`, `branch` and `retired_cnt` drop to 0 without a clock edge. First cycle after release has `instr_valid=0`, then 1 every cycle. `retired_cnt` reads 5 after 5 valid cycles.
- JAL forward:
  - Stimulus: 0x0080006F (JAL x0,+8) at PC 2.
  - Required: `branch=1`, `incrementOffset=0x01`; next cycle `instr_valid=0`; following cycle PC=4 with `instr_valid=1`.
- BEQ backward, taken:
  - Stimulus: 0xFE000EE3 (BEQ x0,x0,-4) at PC 10 with `alu_zero=1`.
  - Required: `incrementOffset=0xFE`, PC sequence 10,11,9; PC 11's word squashed.
- BNE not taken / taken:
  - Stimulus: 0x00001863 (BNE +16) with `alu_zero=1`.
    - Required: `branch=0`, `incrementOffset=0`, no squash.
  - Stimulus: same word with `alu_zero=0`.
    - Required: `branch=1`, `incrementOffset=0x03`.
- Branch in squash slot:
  - Stimulus: two consecutive taken JALs.
  - Required: second has `branch=0` and `instr_valid=0`; `retired_cnt` increments by 1, not 2.
- Counter wrap:
  - Stimulus: with CNT_W=4, run 17 valid instructions.
  - Required: `retired_cnt=1`.
